// File: rtl/tdm_demux_4ch.sv
// Four-channel TDM receive demultiplexer with double-buffered parallel outputs.
// Optional build macro TDM_STICKY_ERR_EN makes sync_err hold until reset.
//
// state | meaning
// IDLE  | not aligned; waiting for a valid sample flagged by sof
// SYNC  | aligned; ch holds the channel expected next
module tdm_demux_4ch #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   input  logic             valid,
   input  logic             sof,
   output logic [WIDTH-1:0] y0,
   output logic [WIDTH-1:0] y1,
   output logic [WIDTH-1:0] y2,
   output logic [WIDTH-1:0] y3,
   output logic             frame_valid,
   output logic             s1,
   output logic             s0,
   output logic             locked,
   output logic             sync_err
);

   typedef enum logic {IDLE = 1'b0, SYNC = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [1:0]       ch_q, ch_d;
   logic [WIDTH-1:0] sh0_q, sh1_q, sh2_q;
   logic             ld_sh0, ld_sh1, ld_sh2, ld_y, err_evt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ch_q    <= 2'd0;
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      if (valid) begin
         case (state_q)
            IDLE: begin
               if (sof) begin
                  state_d = SYNC;
                  ch_d    = 2'd1;
               end
            end
            SYNC: begin
               if (sof) begin
                  ch_d = 2'd1;
               end else if (ch_q == 2'd0) begin
                  state_d = IDLE;
                  ch_d    = 2'd0;
               end else begin
                  ch_d = ch_q + 2'd1;
               end
            end
            default: begin
               state_d = IDLE;
               ch_d    = 2'd0;
            end
         endcase
      end
   end

   // Load strobes for the shadow and output banks, plus the alignment error event.
   always_comb begin
      ld_sh0  = 1'b0;
      ld_sh1  = 1'b0;
      ld_sh2  = 1'b0;
      ld_y    = 1'b0;
      err_evt = 1'b0;
      if (valid) begin
         case (state_q)
            IDLE: ld_sh0 = sof;
            SYNC: begin
               if (sof) begin
                  ld_sh0  = 1'b1;
                  err_evt = (ch_q != 2'd0);
               end else begin
                  case (ch_q)
                     2'd0:    err_evt = 1'b1;
                     2'd1:    ld_sh1  = 1'b1;
                     2'd2:    ld_sh2  = 1'b1;
                     default: ld_y    = 1'b1;
                  endcase
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sh0_q       <= '0;
         sh1_q       <= '0;
         sh2_q       <= '0;
         y0          <= '0;
         y1          <= '0;
         y2          <= '0;
         y3          <= '0;
         frame_valid <= 1'b0;
         sync_err    <= 1'b0;
      end else begin
         if (ld_sh0) sh0_q <= d;
         if (ld_sh1) sh1_q <= d;
         if (ld_sh2) sh2_q <= d;
         if (ld_y) begin
            y0 <= sh0_q;
            y1 <= sh1_q;
            y2 <= sh2_q;
            y3 <= d;
         end
         frame_valid <= ld_y;
`ifdef TDM_STICKY_ERR_EN
         sync_err <= sync_err | err_evt;
`else
         sync_err <= err_evt;
`endif
      end
   end

   assign s1     = ch_q[1];
   assign s0     = ch_q[0];
   assign locked = (state_q == SYNC);

endmodule

// File: tb/tb_tdm_demux_4ch.sv
// Bench for tdm_demux_4ch: directed frames plus random traffic, checked every cycle
// against a queue-based frame-collection model.
module tb_tdm_demux_4ch;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] d = '0;
   logic         valid = 1'b0;
   logic         sof = 1'b0;
   logic [W-1:0] y0, y1, y2, y3;
   logic         frame_valid, s1, s0, locked, sync_err;

   int n_total = 0;
   int n_bad   = 0;

   tdm_demux_4ch #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .d(d), .valid(valid), .sof(sof),
      .y0(y0), .y1(y1), .y2(y2), .y3(y3),
      .frame_valid(frame_valid), .s1(s1), .s0(s0),
      .locked(locked), .sync_err(sync_err)
   );

   always #5 clk = ~clk;

   // model: samples collected for the frame in progress
   logic [W-1:0] m_q[$];
   logic [W-1:0] m_y[4];
   logic         m_locked, m_fv, m_err;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model(input logic r, input logic v, input logic s, input logic [W-1:0] dv);
      logic evt;
      evt  = 1'b0;
      m_fv = 1'b0;
      if (r) begin
         m_q = {};
         for (int i = 0; i < 4; i++) m_y[i] = '0;
         m_locked = 1'b0;
         m_err    = 1'b0;
      end else begin
         if (v) begin
            if (!m_locked) begin
               if (s) begin
                  m_q = {dv};
                  m_locked = 1'b1;
               end
            end else if (s) begin
               if (m_q.size() != 0) evt = 1'b1;
               m_q = {dv};
            end else if (m_q.size() == 0) begin
               evt = 1'b1;
               m_locked = 1'b0;
            end else begin
               m_q.push_back(dv);
               if (m_q.size() == 4) begin
                  for (int i = 0; i < 4; i++) m_y[i] = m_q[i];
                  m_fv = 1'b1;
                  m_q = {};
               end
            end
         end
`ifdef TDM_STICKY_ERR_EN
         m_err = m_err | evt;
`else
         m_err = evt;
`endif
      end
   endtask

   task automatic step(input logic r, input logic v, input logic s, input logic [W-1:0] dv);
      logic [1:0] exp_ch;
      rst = r; valid = v; sof = s; d = dv;
      @(posedge clk);
      model(r, v, s, dv);
      #1;
      exp_ch = 2'(m_q.size());
      chk("y3..y0", {y3, y2, y1, y0}, {m_y[3], m_y[2], m_y[1], m_y[0]});
      chk("frame_valid", 32'(frame_valid), 32'(m_fv));
      chk("select", 32'({s1, s0}), 32'(exp_ch));
      chk("locked", 32'(locked), 32'(m_locked));
      chk("sync_err", 32'(sync_err), 32'(m_err));
   endtask

   task automatic frame(input logic [W-1:0] a, b, c, e);
      step(0, 1, 1, a);
      step(0, 1, 0, b);
      step(0, 1, 0, c);
      step(0, 1, 0, e);
   endtask

   initial begin
      logic v, s, r;
      // reset two cycles
      step(1, 0, 0, 8'h00);
      step(1, 1, 1, 8'hFF);
      chk("reset_y", {y3, y2, y1, y0}, 32'h0);
      // basic frame
      frame(8'h01, 8'h00, 8'h01, 8'h01);
      chk("t2_y", {y3, y2, y1, y0}, 32'h01010001);
      chk("t2_fv", 32'(frame_valid), 32'h1);
      // early sof drops partial frame
      step(0, 1, 1, 8'h00);
      step(0, 1, 0, 8'h01);
      step(0, 1, 0, 8'h00);
      step(0, 1, 1, 8'h01);
      chk("t3_err", 32'(sync_err), 32'h1);
      step(0, 1, 0, 8'h00);
      step(0, 1, 0, 8'h00);
      step(0, 1, 0, 8'h01);
      chk("t3_y", {y3, y2, y1, y0}, 32'h01000001);
      // missing sof after full frame
      step(0, 1, 0, 8'h01);
      chk("t4_locked", 32'(locked), 32'h0);
      step(0, 1, 0, 8'h00);
      step(0, 1, 0, 8'h01);
      // gapped frame, then reset mid-frame
      step(0, 1, 1, 8'h01); step(0, 0, 0, 8'h55); step(0, 0, 1, 8'h55);
      step(0, 1, 0, 8'h01); step(0, 0, 0, 8'h00); step(0, 0, 0, 8'h00);
      step(0, 1, 0, 8'h00); step(0, 0, 1, 8'hAA); step(0, 0, 0, 8'h00);
      step(0, 1, 0, 8'h00);
      chk("t5_y", {y3, y2, y1, y0}, 32'h00000101);
      step(0, 1, 1, 8'h01); step(0, 1, 0, 8'h01);
      step(1, 1, 0, 8'h01);
      chk("t5_rst_locked", 32'(locked), 32'h0);
      // wide samples, early sof, then good frames
      frame(8'hA1, 8'hB2, 8'hC3, 8'hD4);
      chk("t6_y", {y3, y2, y1, y0}, 32'hD4C3B2A1);
      step(0, 1, 1, 8'h11); step(0, 1, 1, 8'h22);
      frame(8'h33, 8'h44, 8'h55, 8'h66);
      frame(8'h77, 8'h88, 8'h99, 8'hAA);
      step(1, 0, 0, 8'h00);
      // random traffic
      for (int i = 0; i < 3000; i++) begin
         r = ($urandom_range(0, 199) == 0);
         v = ($urandom_range(0, 9) < 7);
         if (m_q.size() == 0) s = ($urandom_range(0, 7) != 0);
         else                 s = ($urandom_range(0, 11) == 0);
         step(r, v, s, W'($urandom));
      end
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
